// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage and program counter for the multi-cycle core. Each accepted
// fetch request produces one instruction-memory read at the current PC. The
// returned word is latched into the instruction register (IR), and a one-cycle
// completion pulse goes back to the controller. The PC is updated on its own
// strobe and does not depend on the fetch FSM.
//
// Parameters
//   ADDR_W    PC / memory address width
//   INSTR_W   instruction width (field layout fixed for 16-bit words)
//   RESET_PC  PC value after reset
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   fetch_start    one-cycle fetch request from the controller
//   pc_en          one-cycle PC update strobe
//   pc_ctrl        PC update select: 00 hold, 01 +1, 10 +sext(imm), 11 zext(imm)
//   mem_addr       registered read address (holds until next accepted fetch)
//   mem_req        one-cycle read request
//   mem_rdata      read data, valid with mem_rvalid
//   mem_rvalid     read data valid (only honoured while waiting for data)
//   done           one-cycle pulse: IR has been loaded
//   busy           high from fetch acceptance until done
//   opcode/rd/rs/imm  direct slices of IR: [15:12] [11:10] [9:8] [7:0]
//   pc             current program counter
//   fetch_overrun  sticky: a fetch request arrived while busy
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_start,
    input  logic               pc_en,
    input  logic [1:0]         pc_ctrl,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_req,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_rvalid,
    output logic               done,
    output logic               busy,
    output logic [3:0]         opcode,
    output logic [1:0]         rd,
    output logic [1:0]         rs,
    output logic [7:0]         imm,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_REL  = 2'b10,
        PC_ABS  = 2'b11
    } pc_sel_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_req_q;
    logic                done_q;
    logic                overrun_q;
    logic [INSTR_W-1:0]  ir_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;

    logic [ADDR_W-1:0]   imm_sext;
    logic [ADDR_W-1:0]   imm_zext;

    // -------------------------------------------------------------------------
    // Immediate extension to the address width. The immediate is always 8 bits
    // wide, so narrower address widths simply truncate it.
    // -------------------------------------------------------------------------
    if (ADDR_W > 8) begin : g_ext_wide
        assign imm_sext = {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};
        assign imm_zext = {{(ADDR_W-8){1'b0}},    ir_q[7:0]};
    end else begin : g_ext_narrow
        assign imm_sext = ir_q[ADDR_W-1:0];
        assign imm_zext = ir_q[ADDR_W-1:0];
    end

    // -------------------------------------------------------------------------
    // PC next-state. Uses the IR as it stands before this edge, so a PC update
    // in the same cycle as an IR load still sees the previous immediate.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives pc_d; without it
        // a missing case arm would infer a latch.
        pc_d = pc_q;
        if (pc_en) begin
            unique case (pc_sel_e'(pc_ctrl))
                PC_HOLD: pc_d = pc_q;
                PC_INC:  pc_d = pc_q + ADDR_W'(1);
                PC_REL:  pc_d = pc_q + imm_sext;   // wraps modulo 2^ADDR_W
                PC_ABS:  pc_d = imm_zext;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Fetch FSM with registered outputs. mem_req and done are set on the edge
    // that enters REQ / DONE and cleared on the edge that leaves, so each is a
    // single-cycle pulse aligned with its state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            ir_q       <= '0;
        end else begin
            // Any request while a fetch is in flight is dropped and flagged.
            if (fetch_start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (fetch_start) begin
                        // Pre-update PC: a simultaneous pc_en moves pc_q at this
                        // same edge, but the read targets the old value.
                        mem_addr_q <= pc_q;
                        mem_req_q  <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    mem_req_q <= 1'b0;
                    state_q   <= WAIT;
                end
                WAIT: begin
                    // Data is only accepted here, so a response arriving in the
                    // same cycle as mem_req (still in REQ) is discarded.
                    if (mem_rvalid) begin
                        ir_q    <= mem_rdata;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all registered or decoded straight from registers.
    // -------------------------------------------------------------------------
    assign mem_addr      = mem_addr_q;
    assign mem_req       = mem_req_q;
    assign done          = done_q;
    assign busy          = (state_q != IDLE);
    assign fetch_overrun = overrun_q;
    assign pc            = pc_q;

    assign opcode = ir_q[15:12];
    assign rd     = ir_q[11:10];
    assign rs     = ir_q[9:8];
    assign imm    = ir_q[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives the fetch unit with directed sequences followed by random stimulus.
// A transaction-level reference model tracks, per clock edge, the PC, IR,
// last read address and overrun flag. It tracks the in-flight fetch by the
// edge at which it was accepted and the edge at which data was taken. The
// expected mem_req, done and busy values follow from those timestamps.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;
    localparam int          RST_PC  = 'h10;

    logic               clk = 1'b0;
    logic               rst;
    logic               fetch_start;
    logic               pc_en;
    logic [1:0]         pc_ctrl;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_req;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_rvalid;
    logic               done;
    logic               busy;
    logic [3:0]         opcode;
    logic [1:0]         rd;
    logic [1:0]         rs;
    logic [7:0]         imm;
    logic [ADDR_W-1:0]  pc;
    logic               fetch_overrun;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (8'h10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_start   (fetch_start),
        .pc_en         (pc_en),
        .pc_ctrl       (pc_ctrl),
        .mem_addr      (mem_addr),
        .mem_req       (mem_req),
        .mem_rdata     (mem_rdata),
        .mem_rvalid    (mem_rvalid),
        .done          (done),
        .busy          (busy),
        .opcode        (opcode),
        .rd            (rd),
        .rs            (rs),
        .imm           (imm),
        .pc            (pc),
        .fetch_overrun (fetch_overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  edge_no   = 0;
    int  m_pc      = 0;
    int  m_ir      = 0;
    int  m_addr    = 0;
    bit  m_ovr     = 0;
    bit  in_flight = 0;
    int  t_acc     = -1;   // edge at which the current fetch was accepted
    int  t_resp    = -1;   // edge at which its data was taken (-1: not yet)
    bit  e_req, e_done, e_busy;

    function automatic int wrap(input int v);
        return ((v % 256) + 256) % 256;
    endfunction

    // Apply one clock edge to the model using the inputs driven right now.
    task automatic model_edge();
        int e;
        int imm8;
        e = edge_no;
        if (rst) begin
            m_pc = RST_PC; m_ir = 0; m_addr = 0; m_ovr = 0;
            in_flight = 0; t_acc = -1; t_resp = -1;
        end else begin
            imm8 = m_ir & 'hFF;
            if (pc_en) begin
                case (pc_ctrl)
                    2'b01:   m_pc = wrap(m_pc + 1);
                    2'b10:   m_pc = wrap(m_pc + ((imm8 >= 128) ? imm8 - 256 : imm8));
                    2'b11:   m_pc = imm8;
                    default: ;
                endcase
            end
            if (in_flight) begin
                if (fetch_start) m_ovr = 1;
                if (t_resp >= 0) in_flight = 0;
                else if (mem_rvalid && e >= t_acc + 2) begin
                    m_ir   = int'(mem_rdata);
                    t_resp = e;
                end
            end else if (fetch_start) begin
                in_flight = 1; t_acc = e; t_resp = -1;
                m_addr = int'(pc);   // the PC visible during this cycle
            end
        end
        e_busy = in_flight;
        e_req  = in_flight && (t_acc == e);
        e_done = in_flight && (t_resp == e);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        edge_no++;
        if (done) n_done++;
        check("pc",       32'(pc),            32'(m_pc));
        check("busy",     32'(busy),          32'(e_busy));
        check("done",     32'(done),          32'(e_done));
        check("mem_req",  32'(mem_req),       32'(e_req));
        check("mem_addr", 32'(mem_addr),      32'(m_addr));
        check("ir",       {16'h0, opcode, rd, rs, imm}, 32'(m_ir));
        check("overrun",  32'(fetch_overrun), 32'(m_ovr));
    endtask

    task automatic clear_inputs();
        fetch_start = 0; pc_en = 0; pc_ctrl = 2'b00; mem_rvalid = 0; mem_rdata = '0;
    endtask

    // Full fetch returning 'data' after 'nwait' empty WAIT cycles.
    task automatic do_fetch(input logic [15:0] data, input int nwait);
        fetch_start = 1; step(); fetch_start = 0;   // cycle 1: REQ
        step();                                     // cycle 2: first WAIT
        repeat (nwait) step();
        mem_rvalid = 1; mem_rdata = data; step();   // DONE
        mem_rvalid = 0; step();                     // back to IDLE
    endtask

    task automatic pc_op(input logic [1:0] sel);
        pc_en = 1; pc_ctrl = sel; step(); pc_en = 0; pc_ctrl = 2'b00;
    endtask

    initial begin
        clear_inputs();

        // ---- reset ----
        rst = 1; step(); step(); rst = 0;
        check("rst_pc",      32'(pc), 32'h10);
        check("rst_busy",    32'(busy), 32'h0);
        check("rst_done",    32'(done), 32'h0);
        check("rst_opcode",  32'(opcode), 32'h0);
        check("rst_overrun", 32'(fetch_overrun), 32'h0);

        // ---- zero-wait fetch with PC increment ----
        fetch_start = 1; pc_en = 1; pc_ctrl = 2'b01; step();
        fetch_start = 0; pc_en = 0; pc_ctrl = 2'b00;
        check("zw_req",  32'(mem_req), 32'h1);
        check("zw_addr", 32'(mem_addr), 32'h10);
        check("zw_pc",   32'(pc), 32'h11);
        mem_rvalid = 1; mem_rdata = 16'hBEEF; step();   // same cycle as mem_req: ignored
        check("zw_early_ignored", 32'(opcode), 32'h0);
        mem_rdata = 16'h1A5C; step();
        check("zw_done",   32'(done), 32'h1);
        check("zw_opcode", 32'(opcode), 32'h1);
        check("zw_rd",     32'(rd), 32'h2);
        check("zw_rs",     32'(rs), 32'h2);
        check("zw_imm",    32'(imm), 32'h5C);
        mem_rvalid = 0; step();
        check("zw_idle", 32'(busy), 32'h0);

        // ---- wait states + rvalid while idle ----
        n_done = 0;
        do_fetch(16'h3C21, 5);
        check("ws_done_count", 32'(n_done), 32'd1);
        mem_rvalid = 1; mem_rdata = 16'hFFFF; step(); mem_rvalid = 0;
        check("idle_rvalid_ir", {16'h0, opcode, rd, rs, imm}, 32'h3C21);

        // ---- PC modes ----
        do_fetch(16'h0005, 0); pc_op(2'b11);
        check("pc_abs5", 32'(pc), 32'h05);
        do_fetch(16'h00FE, 1); pc_op(2'b10);
        check("pc_rel_neg", 32'(pc), 32'h03);
        do_fetch(16'h00FF, 0); pc_op(2'b11); pc_op(2'b01);
        check("pc_wrap", 32'(pc), 32'h00);
        do_fetch(16'h0040, 2); pc_op(2'b11);
        check("pc_abs40", 32'(pc), 32'h40);
        pc_op(2'b00);
        check("pc_hold", 32'(pc), 32'h40);

        // ---- overrun ----
        fetch_start = 1; step(); fetch_start = 0; step();   // now in WAIT
        fetch_start = 1; step(); fetch_start = 0;
        check("ovr_no_req", 32'(mem_req), 32'h0);
        check("ovr_set",    32'(fetch_overrun), 32'h1);
        mem_rvalid = 1; mem_rdata = 16'h7123; step(); mem_rvalid = 0; step(); step();
        check("ovr_sticky", 32'(fetch_overrun), 32'h1);
        rst = 1; step(); rst = 0;
        check("ovr_cleared", 32'(fetch_overrun), 32'h0);

        // ---- reset mid-fetch ----
        fetch_start = 1; step(); fetch_start = 0; step(); step();   // WAIT
        rst = 1; step(); rst = 0;
        mem_rvalid = 1; mem_rdata = 16'h9ABC; step(); mem_rvalid = 0;
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_ir",   {16'h0, opcode, rd, rs, imm}, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        n_done = 0;
        do_fetch(16'h4D33, 1);
        check("mid_rst_refetch", {16'h0, opcode, rd, rs, imm}, 32'h4D33);
        check("mid_rst_refetch_done", 32'(n_done), 32'd1);

        // ---- random stimulus against the model ----
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            fetch_start = ($urandom_range(0, 3) == 0);
            pc_en       = ($urandom_range(0, 2) == 0);
            pc_ctrl     = 2'($urandom_range(0, 3));
            mem_rvalid  = ($urandom_range(0, 2) == 0);
            mem_rdata   = 16'($urandom);
            step();
        end
        rst = 0;
        clear_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage and program counter for the multi-cycle core. Owns the PC, issues one instruction-memory read per fetch request from the control state machine and latches the returned word into the instruction register. Decodes the fields the controller and datapath consume. Returns a one-cycle completion pulse that the controller samples as its fetch-done input (`en1`).

## Interface
- `ADDR_W`, 8: PC and memory address width.
- `INSTR_W`, 16: instruction width. Fixed field layout: opcode [15:12], rd [11:10], rs [9:8], imm [7:0].
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch_start`  in  1  one-cycle fetch request (controller `en_fetch_pulse`).
- `pc_en`  in  1  one-cycle PC update strobe (controller `en_pc_pulse`).
- `pc_ctrl`  in  2  PC update select: 00 hold, 01 +1, 10 relative (+ sign-extended imm), 11 absolute (zero-extended imm).
- `mem_addr`  out  ADDR_W  read address, registered.
- `mem_req`  out  1  one-cycle read request.
- `mem_rdata`  in  INSTR_W  read data, valid with `mem_rvalid`.
- `mem_rvalid`  in  1  read-data valid.
- `done`  out  1  one-cycle pulse: IR loaded (to controller `en1`).
- `busy`  out  1  high from `fetch_start` acceptance until `done`.
- `opcode`  out  4  IR[15:12].
- `rd`  out  2  IR[11:10].
- `rs`  out  2  IR[9:8].
- `imm`  out  8  IR[7:0].
- `pc`  out  ADDR_W  current PC.
- `fetch_overrun`  out  1  sticky: `fetch_start` arrived while busy.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: `fetch_start`=1 → latch `mem_addr` ← current `pc` (pre-update value), go REQ. Otherwise stay.
- REQ: `mem_req`=1 for exactly this cycle, go WAIT.
- WAIT: on `mem_rvalid`=1, IR ← `mem_rdata`, go DONE. Otherwise stay; no timeout.
- DONE: `done`=1 for this cycle only, go IDLE.
- `busy` = (state != IDLE).
- `fetch_start` in REQ, WAIT or DONE: the request is ignored, `fetch_overrun` ← 1. Only `rst` clears it.
- `mem_rvalid` outside WAIT is ignored; IR is unchanged.
- IR holds its value between loads. opcode, rd, rs and imm are direct slices of IR.
- PC is independent of the FSM. At an edge with `pc_en`=1 it updates per `pc_ctrl`:
  - 01: pc+1.
  - 10: pc + sign-extend(imm) to ADDR_W.
  - 11: zero-extend(imm) truncated/extended to ADDR_W.
  - 00: hold.
- Arithmetic is modulo 2^ADDR_W and wraps silently. `imm` is the current IR field.
- `fetch_start` and `pc_en` in the same cycle (the normal controller pattern): `mem_addr` takes the old PC, and the PC takes the new value at the same edge.

## Timing
- Reset (`rst`=1 at an edge) sets: state IDLE, `pc`=RESET_PC, IR=0 (all fields 0), `mem_addr`=0, `mem_req`=0, `done`=0, `busy`=0, `fetch_overrun`=0.
- Reset mid-fetch abandons the read. A later `mem_rvalid` is ignored.
- Cycle 0: `fetch_start` sampled.
- Cycle 1: `mem_req`=1, `mem_addr` valid; `mem_addr` then holds until the next accepted start.
- Cycle k (k ≥ 2): earliest `mem_rvalid` sample. `mem_rvalid` asserted in cycle 1 (same cycle as `mem_req`) is ignored.
- Cycle k+1: `done`=1, and fields reflect the new IR.
- Minimum start-to-done latency is 3 cycles. Back-to-back fetch is allowed the cycle after `done`.
- All outputs are registered or decoded from registers. There is no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst` 2 cycles with RESET_PC=0x10 → `pc`=0x10, `busy`=0, `done`=0, `opcode`=0, `fetch_overrun`=0.
- **Zero-wait fetch with PC increment:** `fetch_start`+`pc_en`+`pc_ctrl`=01 at pc=0x10; memory returns 0x1A5C with `mem_rvalid` in cycle 2.
  - `mem_req` in cycle 1 with `mem_addr`=0x10.
  - `done` in cycle 3.
  - opcode=1, rd=2, rs=2, imm=0x5C, `pc`=0x11.
- **Wait states:** `mem_rvalid` delayed 5 cycles after `mem_req` → `busy` high throughout, single `done` pulse, IR loaded only once. A `mem_rvalid` pulse injected while IDLE leaves IR unchanged.
- **PC modes:**
  - pc=0x05, imm=0xFE, `pc_ctrl`=10 → 0x03.
  - pc=0xFF, `pc_ctrl`=01 → 0x00 (wrap).
  - imm=0x40, `pc_ctrl`=11 → 0x40.
  - `pc_ctrl`=00 → unchanged.
- **Overrun:** `fetch_start` again while in WAIT → no second `mem_req`, `fetch_overrun`=1, held after `done` until `rst`.
- **Reset mid-fetch:** `rst` in WAIT, then `mem_rvalid` → no `done`, IR=0, state IDLE; the next `fetch_start` fetches normally.
